// File: rtl/ibuf_ibufg.sv
// Pad input conditioning: per-bit synchronizer plus glitch filter, edge strobes,
// and a bus latch captured on the falling edge of a filtered strobe.

module ibuf_ibufg_bit #(
   parameter int   SYNC_STAGES   = 2,
   parameter int   FILTER_CYCLES = 3,
   parameter logic RST_VAL       = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic pad_i,
   output logic level_o,
   output logic next_o
);
   localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   lvl_q, lvl_d, s;

   assign s = sync_q[SYNC_STAGES-1];

   // A differing sample must be seen FILTER_CYCLES times in a row to be accepted.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      if (s != lvl_q) begin
         if (cnt_q == CMAX) lvl_d = s;
         else               cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         lvl_q  <= RST_VAL;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
         lvl_q  <= lvl_d;
         cnt_q  <= cnt_d;
      end
   end

   assign level_o = lvl_q;
   assign next_o  = lvl_d;
endmodule

module ibuf_ibufg #(
   parameter int               WIDTH         = 8,
   parameter int               BUS_WIDTH     = 8,
   parameter int               SYNC_STAGES   = 2,
   parameter int               FILTER_CYCLES = 3,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     pad_in,
   output logic [WIDTH-1:0]     data_out,
   output logic [WIDTH-1:0]     rise,
   output logic [WIDTH-1:0]     fall,
   input  logic                 strobe_in,
   output logic                 strobe_level,
   input  logic [BUS_WIDTH-1:0] bus_in,
   output logic [BUS_WIDTH-1:0] latched_bus,
   output logic                 latch_valid
);
   logic [WIDTH-1:0] lvl, nxt;
   logic             stb_lvl, stb_nxt;
   logic [WIDTH-1:0] rise_d, fall_d, rise_q, fall_q;
   logic             latch_d, latch_valid_q;
   logic [SYNC_STAGES-1:0][BUS_WIDTH-1:0] bus_q;
   logic [BUS_WIDTH-1:0] latched_q;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      ibuf_ibufg_bit #(
         .SYNC_STAGES  (SYNC_STAGES),
         .FILTER_CYCLES(FILTER_CYCLES),
         .RST_VAL      (RESET_VALUE[g])
      ) u_bit (
         .clock  (clock),
         .reset  (reset),
         .pad_i  (pad_in[g]),
         .level_o(lvl[g]),
         .next_o (nxt[g])
      );
   end

   // Strobe idles high, so its filter resets to 1.
   ibuf_ibufg_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RST_VAL      (1'b1)
   ) u_strobe (
      .clock  (clock),
      .reset  (reset),
      .pad_i  (strobe_in),
      .level_o(stb_lvl),
      .next_o (stb_nxt)
   );

   assign rise_d  = nxt & ~lvl;
   assign fall_d  = lvl & ~nxt;
   assign latch_d = stb_lvl & ~stb_nxt;

   // Bus capture happens on the same edge strobe_level drops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus_q         <= '0;
         latched_q     <= '0;
         latch_valid_q <= 1'b0;
         rise_q        <= '0;
         fall_q        <= '0;
      end else begin
         bus_q         <= {bus_q[SYNC_STAGES-2:0], bus_in};
         latch_valid_q <= latch_d;
         rise_q        <= rise_d;
         fall_q        <= fall_d;
         if (latch_d) latched_q <= bus_q[SYNC_STAGES-1];
      end
   end

   assign data_out     = lvl;
   assign rise         = rise_q;
   assign fall         = fall_q;
   assign strobe_level = stb_lvl;
   assign latched_bus  = latched_q;
   assign latch_valid  = latch_valid_q;
endmodule

// File: tb/tb_ibuf_ibufg.sv
// Scoreboard bench for ibuf_ibufg: stimulus pushes expected pulses with their
// due cycle, a negedge monitor pops and compares them as the DUT produces them.

module tb_ibuf_ibufg;
   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] pad_in, data_out, rise, fall, bus_in, latched_bus;
   logic       strobe_in, strobe_level, latch_valid;

   ibuf_ibufg dut (
      .clock       (clock),
      .reset       (reset),
      .pad_in      (pad_in),
      .data_out    (data_out),
      .rise        (rise),
      .fall        (fall),
      .strobe_in   (strobe_in),
      .strobe_level(strobe_level),
      .bus_in      (bus_in),
      .latched_bus (latched_bus),
      .latch_valid (latch_valid)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct { int cyc; logic [7:0] rise; logic [7:0] fall; logic [7:0] data; } pev_t;
   typedef struct { int cyc; logic [7:0] bus; } lev_t;
   pev_t pq[$];
   lev_t lq[$];
   pev_t pe;
   lev_t le;
   logic [7:0] model;

   // Latency from drive (just after edge n) to output edge: n+1 sample, +4.
   localparam int LAT = 5;

   task automatic tick(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic drive_pad(input logic [7:0] nv);
      pev_t e;
      pad_in = nv;
      e.cyc  = cyc + LAT;
      e.rise = nv & ~model;
      e.fall = ~nv & model;
      e.data = nv;
      pq.push_back(e);
      model = nv;
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (pq.size() > 0 && pq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missed_pulse at cyc %0d, required at cyc %0d", cyc, pq[0].cyc);
            pq.delete(0);
         end
         if (lq.size() > 0 && lq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missed_latch at cyc %0d, required at cyc %0d", cyc, lq[0].cyc);
            lq.delete(0);
         end
         if (rise !== 8'h00 || fall !== 8'h00) begin
            checks++;
            if (pq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse cyc %0d rise %h fall %h", cyc, rise, fall);
            end else begin
               pe = pq.pop_front();
               if (pe.cyc !== cyc || rise !== pe.rise || fall !== pe.fall || data_out !== pe.data) begin
                  errors++;
                  $display("FAIL pulse cyc %0d rise %h fall %h data %h, required cyc %0d rise %h fall %h data %h",
                           cyc, rise, fall, data_out, pe.cyc, pe.rise, pe.fall, pe.data);
               end
            end
         end
         if (latch_valid !== 1'b0) begin
            checks++;
            if (lq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_latch cyc %0d bus %h", cyc, latched_bus);
            end else begin
               le = lq.pop_front();
               if (le.cyc !== cyc || latched_bus !== le.bus || strobe_level !== 1'b0) begin
                  errors++;
                  $display("FAIL latch cyc %0d bus %h lvl %b, required cyc %0d bus %h lvl 0",
                           cyc, latched_bus, strobe_level, le.cyc, le.bus);
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1; pad_in = 8'hFF; strobe_in = 1'b1; bus_in = 8'h5A; model = 8'h00;
      tick(4);
      checks++;
      if (data_out !== 8'h00 || rise !== 8'h00 || fall !== 8'h00) begin
         errors++;
         $display("FAIL reset_pads data %h rise %h fall %h, required 00 00 00", data_out, rise, fall);
      end
      checks++;
      if (strobe_level !== 1'b1 || latched_bus !== 8'h00 || latch_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobe lvl %b bus %h valid %b, required 1 00 0", strobe_level, latched_bus, latch_valid);
      end
      pad_in = 8'h00;
      tick(1);
      reset = 1'b0;
      tick(10);
      checks++;
      if (data_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_release data %h, required 00", data_out);
      end
   endtask

   task automatic test_clean_edge();
      drive_pad(8'h08);
      tick(8);
      checks++;
      if (data_out !== 8'h08) begin
         errors++;
         $display("FAIL clean_rise_level data %h, required 08", data_out);
      end
      drive_pad(8'h00);
      tick(8);
   endtask

   task automatic test_glitch();
      pad_in = 8'h01;
      tick(2);
      pad_in = 8'h00;
      tick(8);
      checks++;
      if (data_out !== 8'h00) begin
         errors++;
         $display("FAIL glitch_2cyc data %h, required 00", data_out);
      end
      drive_pad(8'h01);
      tick(3);
      drive_pad(8'h00);
      tick(10);
   endtask

   task automatic test_multi_bit();
      drive_pad(8'hA5);
      tick(8);
      checks++;
      if (data_out !== 8'hA5) begin
         errors++;
         $display("FAIL multi_level data %h, required a5", data_out);
      end
      drive_pad(8'h00);
      tick(8);
   endtask

   task automatic test_latch();
      lev_t e;
      bus_in = 8'h12;
      tick(3);
      strobe_in = 1'b0;
      e.cyc = cyc + LAT; e.bus = 8'h12; lq.push_back(e);
      tick(8);
      checks++;
      if (strobe_level !== 1'b0 || latched_bus !== 8'h12) begin
         errors++;
         $display("FAIL latch_fall lvl %b bus %h, required 0 12", strobe_level, latched_bus);
      end
      bus_in = 8'h34;
      tick(3);
      strobe_in = 1'b1;
      tick(8);
      checks++;
      if (strobe_level !== 1'b1 || latched_bus !== 8'h12) begin
         errors++;
         $display("FAIL latch_rise lvl %b bus %h, required 1 12", strobe_level, latched_bus);
      end
      strobe_in = 1'b0;
      e.cyc = cyc + LAT; e.bus = 8'h34; lq.push_back(e);
      tick(8);
      strobe_in = 1'b1;
      tick(8);
   endtask

   task automatic test_reset_mid();
      drive_pad(8'h80);
      tick(8);
      pad_in = 8'h82;
      tick(2);
      reset = 1'b1;
      #1;
      checks++;
      if (data_out !== 8'h00 || latched_bus !== 8'h00 || strobe_level !== 1'b1) begin
         errors++;
         $display("FAIL reset_async data %h bus %h lvl %b, required 00 00 1", data_out, latched_bus, strobe_level);
      end
      model = 8'h00;
      tick(2);
      reset = 1'b0;
      drive_pad(8'h82);
      tick(8);
      checks++;
      if (data_out !== 8'h82) begin
         errors++;
         $display("FAIL reset_mid_level data %h, required 82", data_out);
      end
      drive_pad(8'h00);
      tick(8);
   endtask

   initial begin
      test_reset();
      test_clean_edge();
      test_glitch();
      test_multi_bit();
      test_latch();
      test_reset_mid();
      tick(4);
      checks++;
      if (pq.size() != 0 || lq.size() != 0) begin
         errors++;
         $display("FAIL leftover_events pulses %0d latches %0d, required 0 0", pq.size(), lq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
